// File: rtl/barrett_mu_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module : barrett_mu_gen_pkg
// Brief  : Shared width default, FSM encoding and saturation constant for the
//          Barrett mu generator.
// Rev    : 1.0
// ============================================================================
package barrett_mu_gen_pkg;

   localparam int WIDTH_DEFAULT = 64;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [WIDTH_DEFAULT-1:0] MU_SAT = '1;

endpackage
`default_nettype wire

// File: rtl/barrett_div_step.sv
`default_nettype none
// ============================================================================
// Module : barrett_div_step
// Brief  : One restoring-division step: shift in a dividend bit, compare
//          against q, conditionally subtract.
// Rev    : 1.0
// ============================================================================
module barrett_div_step #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH:0]   rem,
   input  logic [WIDTH-1:0] q,
   input  logic             dividend_bit,
   output logic [WIDTH:0]   rem_next,
   output logic             q_bit
);

   logic [WIDTH:0] w_trial;
   logic [WIDTH:0] w_q_ext;
   logic           unused_rem_msb;

   // The remainder is always < q, so its top bit is zero and drops out of the shift.
   assign unused_rem_msb = rem[WIDTH];

   assign w_trial  = {rem[WIDTH-1:0], dividend_bit};
   assign w_q_ext  = {1'b0, q};
   assign q_bit    = (w_trial >= w_q_ext);
   assign rem_next = q_bit ? (w_trial - w_q_ext) : w_trial;

endmodule
`default_nettype wire

// File: rtl/barrett_mu_gen.sv
`default_nettype none
// ============================================================================
// Module : barrett_mu_gen
// Brief  : Sequential generator of mu = floor(2^WIDTH / q) by restoring long
//          division, one quotient bit per cycle, valid/ready on both sides.
// Rev    : 1.0
// ============================================================================
module barrett_mu_gen
   import barrett_mu_gen_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] q_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] q_out,
   output logic [WIDTH-1:0] mu_out,
   output logic             err
);

   localparam int             CNT_W    = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] C_MU_SAT = {WIDTH{MU_SAT[0]}};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH:0]   r_rem;
   logic [WIDTH:0]   r_quo;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_mu;
   logic             r_err;
   logic             r_out_valid;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH:0]   w_rem_nxt;
   logic             w_q_bit;
   logic             w_div_bit;
   logic             w_q_small;
   logic             unused_quo_msb;

   // 2^WIDTH fed MSB-first: the leading one lands on the first iteration only.
   assign w_div_bit      = (r_cnt == CNT_W'(WIDTH));
   assign w_q_small      = (r_q < WIDTH'(2));
   assign unused_quo_msb = r_quo[WIDTH];

   barrett_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem          (r_rem),
      .q            (r_q),
      .dividend_bit (w_div_bit),
      .rem_next     (w_rem_nxt),
      .q_bit        (w_q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (in_valid)                 w_state_nxt = ST_RUN;
         ST_RUN:  if (r_cnt == '0)              w_state_nxt = ST_DONE;
         ST_DONE: if (r_out_valid && out_ready) w_state_nxt = ST_IDLE;
         default:                               w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rem       <= '0;
         r_quo       <= '0;
         r_q         <= '0;
         r_mu        <= '0;
         r_err       <= 1'b0;
         r_out_valid <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_q   <= q_in;
                  r_rem <= '0;
                  r_quo <= '0;
                  r_cnt <= CNT_W'(WIDTH);
               end
            end
            ST_RUN: begin
               r_rem <= w_rem_nxt;
               r_quo <= {r_quo[WIDTH-1:0], w_q_bit};
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            ST_DONE: begin
               // Result is registered one cycle after the last step; q < 2 saturates.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_mu        <= w_q_small ? C_MU_SAT : r_quo[WIDTH-1:0];
                  r_err       <= w_q_small;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = r_out_valid;
   assign q_out     = r_q;
   assign mu_out    = r_mu;
   assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_barrett_mu_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_barrett_mu_gen
// Brief  : Directed, table-driven self-checking bench for barrett_mu_gen.
// Rev    : 1.0
// ============================================================================
module tb_barrett_mu_gen;

   localparam int W   = 64;
   localparam int LAT = W + 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] q_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] q_out;
   logic [W-1:0] mu_out;
   logic         err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] mu;
      logic         err;
   } vec_t;

   vec_t vecs [8];

   barrett_mu_gen #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .q_in      (q_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q_out     (q_out),
      .mu_out    (mu_out),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 right after the accepting edge.
   task automatic accept(input logic [W-1:0] q);
      int k;
      in_valid = 1'b1;
      q_in     = q;
      k        = 0;
      @(negedge clk);
      while (!in_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      q_in     = $urandom();
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("in_ready_after_take", 64'(in_ready), 64'd1);
      check("out_valid_after_take", 64'(out_valid), 64'd0);
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      accept(v.q);
      wait_valid(n);
      check("latency", 64'(n), 64'(LAT));
      check("mu_out", mu_out, v.mu);
      check("err", 64'(err), 64'(v.err));
      check("q_out", q_out, v.q);
      take();
   endtask

   initial begin
      int   n;
      logic seen;
      logic [W-1:0] hold_mu;

      vecs[0] = '{q: 64'd17,                  mu: 64'h0F0F0F0F0F0F0F0F, err: 1'b0};
      vecs[1] = '{q: 64'hFFFFFFFF00000001,    mu: 64'd1,                err: 1'b0};
      vecs[2] = '{q: 64'h8000000000000000,    mu: 64'd2,                err: 1'b0};
      vecs[3] = '{q: 64'd1,                   mu: 64'hFFFFFFFFFFFFFFFF, err: 1'b1};
      vecs[4] = '{q: 64'd0,                   mu: 64'hFFFFFFFFFFFFFFFF, err: 1'b1};
      vecs[5] = '{q: 64'd5,                   mu: 64'h3333333333333333, err: 1'b0};
      vecs[6] = '{q: 64'hFFFFFFFFFFFFFFFF,    mu: 64'd1,                err: 1'b0};
      vecs[7] = '{q: 64'd2,                   mu: 64'h8000000000000000, err: 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      q_in      = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      check("reset_in_ready", 64'(in_ready), 64'd1);
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_mu_out", mu_out, 64'd0);
      check("reset_q_out", q_out, 64'd0);
      check("reset_err", 64'(err), 64'd0);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i]);
      end

      // q=3 then q=2 held while busy; result stalled for 10 cycles.
      accept(64'd3);
      in_valid = 1'b1;
      q_in     = 64'd2;
      wait_valid(n);
      check("b2b_latency", 64'(n), 64'(LAT));
      check("b2b_mu_first", mu_out, 64'h5555555555555555);
      check("b2b_q_first", q_out, 64'd3);
      hold_mu = mu_out;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         check("stall_out_valid", 64'(out_valid), 64'd1);
         check("stall_in_ready", 64'(in_ready), 64'd0);
         check("stall_mu", mu_out, hold_mu);
      end
      take();
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("b2b_second_accepted", 64'(in_ready), 64'd0);
      wait_valid(n);
      check("b2b_latency2", 64'(n), 64'(LAT));
      check("b2b_mu_second", mu_out, 64'h8000000000000000);
      check("b2b_q_second", q_out, 64'd2);
      check("b2b_err_second", 64'(err), 64'd0);
      take();

      // Reset in the middle of a division discards it.
      accept(64'd17);
      repeat (30) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("midrst_in_ready", 64'(in_ready), 64'd1);
      check("midrst_out_valid", 64'(out_valid), 64'd0);
      check("midrst_mu_out", mu_out, 64'd0);
      check("midrst_q_out", q_out, 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      seen = 1'b0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      check("midrst_no_result", 64'(seen), 64'd0);
      run_vec(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
